// File: rtl/insmem_arbiter.sv
// Round-robin arbiter sharing one single-port, registered-read instruction memory among
// NUM_CORES fetch units, with a loader write port that always takes precedence.
module insmem_arbiter #(
  parameter int NUM_CORES  = 4,
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CORES-1:0]            req,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0] core_addr,
  output logic [NUM_CORES-1:0]            grant,
  output logic [NUM_CORES-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]           rdata,
  input  logic                            ld_wrEn,
  input  logic [ADDR_WIDTH-1:0]           ld_addr,
  input  logic [DATA_WIDTH-1:0]           ld_data,
  output logic                            mem_wrEn,
  output logic [ADDR_WIDTH-1:0]           mem_address,
  output logic [DATA_WIDTH-1:0]           mem_dataIn,
  input  logic [DATA_WIDTH-1:0]           mem_dataOut
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [PTR_W-1:0]      r_rr_ptr;
  logic [NUM_CORES-1:0]  r_rvalid;

  logic [ADDR_WIDTH-1:0] w_core_addr [NUM_CORES];
  logic [PTR_W-1:0]      w_idx;
  logic [PTR_W-1:0]      w_sel;
  logic                  w_found;
  logic                  w_core_win;
  logic [PTR_W-1:0]      w_next_ptr;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_addr_split
    assign w_core_addr[g] = core_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // First requester when scanning from r_rr_ptr upward, wrapping mod NUM_CORES.
  // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_idx = PTR_W'((int'(r_rr_ptr) + i) % NUM_CORES);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  assign w_core_win = w_found && !ld_wrEn && !rst;
  assign w_next_ptr = (w_sel == PTR_W'(NUM_CORES - 1)) ? '0 : w_sel + 1'b1;

  always_comb begin
    grant       = '0;
    mem_address = '0;
    if (!rst && ld_wrEn) begin
      mem_address = ld_addr;
    end else if (w_core_win) begin
      grant       = NUM_CORES'(1) << w_sel;
      mem_address = w_core_addr[w_sel];
    end
  end

  assign mem_wrEn   = ld_wrEn && !rst;
  assign mem_dataIn = ld_data;
  assign rdata      = mem_dataOut;
  assign rvalid     = r_rvalid;

  // The memory returns data one cycle after the address, so rvalid is the grant delayed by one.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_rvalid <= '0;
    end else begin
      r_rvalid <= grant;
      if (w_core_win) r_rr_ptr <= w_next_ptr;
    end
  end

  a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_rvalid_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(rvalid));

endmodule

// File: tb/tb_insmem_arbiter.sv
// Self-checking bench for insmem_arbiter: directed scenarios then randomized traffic,
// checked against a last-winner round-robin model with its own copy of memory contents.
module tb_insmem_arbiter;

  localparam int N = 4;
  localparam int D = 12;
  localparam int A = 12;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*A-1:0] core_addr;
  logic [N-1:0]   grant;
  logic [N-1:0]   rvalid;
  logic [D-1:0]   rdata;
  logic           ld_wrEn;
  logic [A-1:0]   ld_addr;
  logic [D-1:0]   ld_data;
  logic           mem_wrEn;
  logic [A-1:0]   mem_address;
  logic [D-1:0]   mem_dataIn;
  logic [D-1:0]   mem_dataOut;

  insmem_arbiter #(.NUM_CORES(N), .DATA_WIDTH(D), .ADDR_WIDTH(A)) dut (
    .clk(clk), .rst(rst), .req(req), .core_addr(core_addr), .grant(grant),
    .rvalid(rvalid), .rdata(rdata), .ld_wrEn(ld_wrEn), .ld_addr(ld_addr),
    .ld_data(ld_data), .mem_wrEn(mem_wrEn), .mem_address(mem_address),
    .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut)
  );

  always #5 clk = ~clk;

  // Registered-read single-port memory attached to the DUT.
  logic [D-1:0] mem [1 << A];
  always @(posedge clk) begin
    if (mem_wrEn) mem[mem_address] <= mem_dataIn;
    mem_dataOut <= mem[mem_address];
  end

  // Reference model: memory image, last granted core, and the read expected next cycle.
  logic [D-1:0] ref_mem [1 << A];
  int           ref_last;
  logic [N-1:0] exp_rvalid;
  logic [D-1:0] exp_rdata;
  logic [N-1:0] last_eg;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    ref_last   = N - 1;
    exp_rvalid = '0;
    last_eg    = '0;
  endtask

  task automatic set_addr(input int c, input logic [A-1:0] a);
    core_addr[c*A +: A] = a;
  endtask

  // One clock cycle: check combinational and registered outputs mid-cycle, advance the model.
  task automatic step();
    logic [N-1:0] eg;
    logic [A-1:0] ea;
    int           k;
    @(negedge clk);
    eg = '0;
    k  = -1;
    if (!ld_wrEn) begin
      for (int j = 1; j <= N; j++) begin
        int c;
        c = (ref_last + j) % N;
        if (k < 0 && req[c]) k = c;
      end
    end
    if (k >= 0) eg[k] = 1'b1;
    ea = ld_wrEn ? ld_addr : ((k >= 0) ? core_addr[k*A +: A] : '0);
    check("grant", 32'(grant), 32'(eg));
    check("mem_wrEn", 32'(mem_wrEn), 32'(ld_wrEn));
    check("mem_address", 32'(mem_address), 32'(ea));
    check("rvalid", 32'(rvalid), 32'(exp_rvalid));
    if (exp_rvalid != '0) check("rdata", 32'(rdata), 32'(exp_rdata));
    if (ld_wrEn) check("mem_dataIn", 32'(mem_dataIn), 32'(ld_data));
    exp_rvalid = eg;
    last_eg    = eg;
    if (k >= 0) begin
      exp_rdata = ref_mem[ea];
      ref_last  = k;
    end
    if (ld_wrEn) ref_mem[ld_addr] = ld_data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req = '0; core_addr = '0;
    ld_wrEn = 1'b0; ld_addr = '0; ld_data = '0;
    for (int i = 0; i < (1 << A); i++) begin
      logic [D-1:0] v;
      v = D'($urandom);
      mem[i]     = v;
      ref_mem[i] = v;
    end
    model_reset();

    // Reset holds grant, rvalid and mem_wrEn low even with every core requesting.
    req = 4'b1111;
    #1;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    @(posedge clk); #1;
    ld_wrEn = 1'b1;
    #1;
    check("rst_mem_wrEn", 32'(mem_wrEn), 32'h0);
    check("rst_grant2", 32'(grant), 32'h0);
    ld_wrEn = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rel_grant", 32'(grant), 32'h1);

    // All cores requesting: strict rotation for 8 cycles.
    for (int i = 0; i < 8; i++) begin
      check("rr_grant", 32'(grant), 32'(4'b0001 << (i % N)));
      step();
    end
    req = '0;
    step();

    // Preload 0x010 through the loader, then a single core2 fetch.
    ld_wrEn = 1'b1; ld_addr = 12'h010; ld_data = 12'hABC;
    step();
    ld_wrEn = 1'b0;
    set_addr(2, 12'h010);
    req = 4'b0100;
    #1;
    check("single_grant", 32'(grant), 32'h4);
    step();
    req = '0;
    check("single_rvalid", 32'(rvalid), 32'h4);
    check("single_rdata", 32'(rdata), 32'hABC);
    step();

    // Loader and core0 hit the same address: loader first, core0 then reads the new word.
    ld_wrEn = 1'b1; ld_addr = 12'h020; ld_data = 12'h5A5;
    set_addr(0, 12'h020);
    req = 4'b0001;
    #1;
    check("ld_grant", 32'(grant), 32'h0);
    check("ld_mem_wrEn", 32'(mem_wrEn), 32'h1);
    step();
    ld_wrEn = 1'b0;
    #1;
    check("ld_after_grant", 32'(grant), 32'h1);
    step();
    req = '0;
    check("ld_rdata", 32'(rdata), 32'h5A5);
    step();

    // Bring the pointer to 3 via a core2 grant, then req=0110 skips/wraps: core1 then core2.
    req = 4'b0100;
    step();
    req = 4'b0110;
    #1;
    check("wrap_grant1", 32'(grant), 32'h2);
    step();
    check("wrap_grant2", 32'(grant), 32'h4);
    step();
    req = '0;
    step();

    // Reset between a core1 grant and the following edge drops the read and clears the pointer.
    req = 4'b0010;
    #1;
    check("midrst_grant", 32'(grant), 32'h2);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_grant_low", 32'(grant), 32'h0);
    check("midrst_rvalid", 32'(rvalid), 32'h0);
    @(posedge clk); #1;
    check("midrst_rvalid2", 32'(rvalid), 32'h0);
    rst = 1'b0;
    model_reset();
    req = 4'b1111;
    #1;
    check("midrst_ptr0", 32'(grant), 32'h1);
    step();
    req = '0;
    step();

    // Randomized traffic: requests held until granted, occasional loader writes to a shared window.
    last_eg = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if (last_eg[c]) begin
          req[c] = 1'($urandom_range(0, 1));
          if (req[c]) set_addr(c, A'($urandom_range(0, 63)));
        end else if (!req[c] && $urandom_range(0, 2) == 0) begin
          req[c] = 1'b1;
          set_addr(c, A'($urandom_range(0, 63)));
        end
      end
      ld_wrEn = ($urandom_range(0, 4) == 0);
      ld_addr = A'($urandom_range(0, 63));
      ld_data = D'($urandom);
      step();
    end
    ld_wrEn = 1'b0;
    req = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
